scan_seq_ctrl: RTL and testbench

Sequencer for the array scan/readout path.
- On a start request it walks a linear read address (read_select) across the ROWS x COLS result store.
- It waits the store's fixed read latency for each address, captures the read byte, and hands it to the UART transmitter with a valid/ready handshake.
- It flags row and scan boundaries, and sits between the systolic result memory and the UART TX.

---
 rtl/scan_seq_ctrl.sv | 121 ++++++++++++
 tb/tb_scan_seq_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_seq_ctrl.sv
// rtl/scan_seq_ctrl.sv - scan/readout sequencer from result store to UART TX (optional macro SCAN_CONTINUOUS_EN)
module scan_seq_ctrl #(
  parameter int ROWS   = 64,
  parameter int COLS   = 64,
  parameter int ADDR_W = 14,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rd_data,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] read_select,
  output logic              scan_start,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  output logic              row_last,
  output logic              busy,
  output logic              done
);

  localparam int DEPTH = ROWS * COLS;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(COLS - 1);
  // Index of the last latency cycle: the WAIT state spans RD_LAT edges after
  // the address step, so rd_data is captured on the edge where lat_cnt hits this.
  localparam logic [3:0]        LAT_LAST  = 4'(RD_LAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    SEND,
    FINISH
  } state_t;

  state_t            state;
  logic              start_d;
  logic [3:0]        lat_cnt;
  logic [ADDR_W-1:0] col_cnt;
  logic              start_edge;

  // start_d clears in reset, so a start held through reset release is an edge.
  assign start_edge = start & ~start_d;

  // Scan sequencer: every output is registered and updated on the edge that leaves a state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      start_d     <= 1'b0;
      lat_cnt     <= '0;
      col_cnt     <= '0;
      read_select <= '0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      row_last    <= 1'b0;
      scan_start  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      start_d    <= start;
      scan_start <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          // Edges seen in any other state fall through here and are dropped.
          if (start_edge) begin
            state <= LAUNCH;
          end
        end
        LAUNCH: begin
          scan_start  <= 1'b1;
          busy        <= 1'b1;
          read_select <= '0;
          col_cnt     <= '0;
          lat_cnt     <= '0;
          state       <= WAIT;
        end
        WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            tx_data  <= rd_data;
            tx_valid <= 1'b1;
            row_last <= (col_cnt == LAST_COL);
            state    <= SEND;
          end else begin
            lat_cnt <= lat_cnt + 4'd1;
          end
        end
        SEND: begin
          // tx_data/row_last stay frozen until the UART takes the byte.
          if (tx_ready) begin
            tx_valid <= 1'b0;
            row_last <= 1'b0;
            lat_cnt  <= '0;
            if (read_select == LAST_ADDR) begin
              state <= FINISH;
            end else begin
              read_select <= read_select + 1'b1;
              col_cnt     <= (col_cnt == LAST_COL) ? '0 : col_cnt + 1'b1;
              state       <= WAIT;
            end
          end
        end
        FINISH: begin
          // read_select is left at the last address until the next LAUNCH.
          done <= 1'b1;
          busy <= 1'b0;
`ifdef SCAN_CONTINUOUS_EN
          state <= start ? LAUNCH : IDLE;
`else
          state <= IDLE;
`endif
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_seq_ctrl.sv
// tb/tb_scan_seq_ctrl.sv - directed bench for scan_seq_ctrl (4x4 store, RD_LAT=2)
module tb_scan_seq_ctrl;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int ADDR_W = 14;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = ROWS * COLS;
`ifdef SCAN_CONTINUOUS_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              tx_ready = 1'b0;
  logic [7:0]        rd_data;
  logic [ADDR_W-1:0] read_select;
  logic              scan_start;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              row_last;
  logic              busy;
  logic              done;
  logic [7:0]        store_q;

  int checks = 0;
  int errors = 0;
  int n = 0;
  int done_cnt = 0;
  int ss_cnt = 0;
  int exp_done_n = 0;

  typedef struct {
    int                stall;
    logic [ADDR_W-1:0] exp_addr;
    logic [7:0]        exp_data;
    logic              exp_rl;
    int                exp_n;
  } vec_t;

  vec_t vec [DEPTH];

  scan_seq_ctrl #(
    .ROWS(ROWS),
    .COLS(COLS),
    .ADDR_W(ADDR_W),
    .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .rd_data(rd_data),
    .tx_ready(tx_ready),
    .read_select(read_select),
    .scan_start(scan_start),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .row_last(row_last),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  // Result store model: byte at address a is a[7:0], ready in the RD_LAT-th cycle.
  always @(posedge clk) store_q <= read_select[7:0];
  assign rd_data = store_q;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (n=%0d)", name, act, exp, n);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    n++;
    if (done) done_cnt++;
    if (scan_start) ss_cnt++;
  endtask

  task automatic fill_table(input int stall_idx, input int stall_len);
    logic [15:0] rl_pattern;
    rl_pattern = 16'b1000_1000_1000_1000;
    for (int k = 0; k < DEPTH; k++) begin
      vec[k].stall    = (k == stall_idx) ? stall_len : 0;
      vec[k].exp_addr = ADDR_W'(k);
      vec[k].exp_data = 8'(k);
      vec[k].exp_rl   = rl_pattern[k];
      vec[k].exp_n    = 3 + 3 * k + ((k > stall_idx) ? stall_len : 0);
    end
    exp_done_n = 50 + ((stall_idx < DEPTH) ? stall_len : 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_read_select"}, 32'(read_select), 32'd0);
    check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
    check({tag, "_row_last"}, 32'(row_last), 32'd0);
    check({tag, "_scan_start"}, 32'(scan_start), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // One complete scan from a fresh rising edge, checked against vec[].
  task automatic full_scan(input bit toggle);
    int guard;
    int d0;
    d0 = done_cnt;
    tx_ready = 1'b1;
    start = 1'b1;
    n = -1;
    tick();
    check("launch_lead_scan_start", 32'(scan_start), 32'd0);
    tick();
    check("scan_start_pulse", 32'(scan_start), 32'd1);
    check("busy_at_launch", 32'(busy), 32'd1);
    check("read_select_at_launch", 32'(read_select), 32'd0);
    for (int k = 0; k < DEPTH; k++) begin
      guard = 0;
      while (!tx_valid && guard < 40) begin
        tick();
        guard++;
        if (toggle) start = ~start;
      end
      if (!tx_valid) begin
        check("tx_valid_timeout", 32'(tx_valid), 32'd1);
        start = 1'b0;
        return;
      end
      check("byte_latency", 32'(n), 32'(vec[k].exp_n));
      check("tx_data", 32'(tx_data), 32'(vec[k].exp_data));
      check("row_last", 32'(row_last), 32'(vec[k].exp_rl));
      check("read_select", 32'(read_select), 32'(vec[k].exp_addr));
      if (vec[k].stall > 0) begin
        tx_ready = 1'b0;
        for (int s = 0; s < vec[k].stall; s++) begin
          tick();
          check("stall_tx_valid", 32'(tx_valid), 32'd1);
          check("stall_tx_data", 32'(tx_data), 32'(vec[k].exp_data));
          check("stall_read_select", 32'(read_select), 32'(vec[k].exp_addr));
        end
        tx_ready = 1'b1;
      end
      tick();
      check("tx_valid_clear", 32'(tx_valid), 32'd0);
    end
    start = 1'b0;
    guard = 0;
    while (!done && guard < 10) begin
      tick();
      guard++;
    end
    check("done_seen", 32'(done), 32'd1);
    check("done_cycle", 32'(n), 32'(exp_done_n));
    check("busy_at_done", 32'(busy), 32'd0);
    check("read_select_hold", 32'(read_select), 32'(DEPTH - 1));
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
    check("done_per_scan", 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int d0;
    int s0;
    int guard;
    int first_done;
    logic prev_done;

    // Start held through reset counts as an edge at release.
    rst = 1'b1;
    start = 1'b1;
    tx_ready = 1'b1;
    repeat (50) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check("release_lead_scan_start", 32'(scan_start), 32'd0);
    tick();
    check("release_scan_start", 32'(scan_start), 32'd1);
    check("release_read_select", 32'(read_select), 32'd0);
    check("release_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    start = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Plain scan, tx_ready always high.
    fill_table(DEPTH, 0);
    full_scan(1'b0);
    tick();

    // Ten-cycle stall on byte 5.
    fill_table(5, 10);
    full_scan(1'b0);
    tick();

    // start toggled while busy: one scan, one done.
    fill_table(DEPTH, 0);
    d0 = done_cnt;
    s0 = ss_cnt;
    full_scan(1'b1);
    repeat (60) tick();
    check("toggle_done_count", 32'(done_cnt - d0), 32'd1);
    check("toggle_scan_start_count", 32'(ss_cnt - s0), 32'd1);

    // Reset while byte 9 is offered, then a fresh scan from address 0.
    tx_ready = 1'b1;
    start = 1'b1;
    n = -1;
    guard = 0;
    while (!(tx_valid && read_select == ADDR_W'(9)) && guard < 100) begin
      tick();
      guard++;
    end
    check("abort_at_byte9_valid", 32'(tx_valid), 32'd1);
    check("abort_at_byte9_data", 32'(tx_data), 32'h09);
    d0 = done_cnt;
    rst = 1'b1;
    start = 1'b0;
    tick();
    check_all_zero("abort");
    rst = 1'b0;
    repeat (60) tick();
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_idle_busy", 32'(busy), 32'd0);
    fill_table(DEPTH, 0);
    full_scan(1'b0);
    tick();

    // start held high: back-to-back scans only in continuous mode.
    d0 = done_cnt;
    s0 = ss_cnt;
    first_done = -1;
    prev_done = 1'b0;
    start = 1'b1;
    n = -1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (prev_done) check("scan_start_after_done", 32'(scan_start), 32'(CONT));
      prev_done = done;
      if (done && first_done < 0) first_done = n;
      if (n == 120) start = 1'b0;
    end
    check("held_first_done_cycle", 32'(first_done), 32'd50);
    check("held_done_count", 32'(done_cnt - d0), CONT ? 32'd3 : 32'd1);
    check("held_scan_start_count", 32'(ss_cnt - s0), CONT ? 32'd3 : 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
